core_run_ctrl: RTL and testbench

Synthesizable run controller for the single-cycle RV32I core. Sits beside `top`: it drives the core's reset and consumes the core's committed PC and misalignment flag. It sequences core reset release, counts executed cycles, and stops the run on halt-PC, self-loop, misaligned access, or timeout. Status outputs feed LEDs on FPGA builds and the bench's stop logic in simulation.

---
 rtl/core_run_pkg.sv | 25 ++
 rtl/core_run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_core_run_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_pkg.sv
// Shared types for the run controller of the single-cycle RV32I core.
//
// Contents:
//   XLEN        - architectural register / PC width.
//   run_state_e - run controller FSM states (HOLD, RUN, DONE).
//   run_end_e   - reason a run ended; decoded into the halted/fault/timeout
//                 status flags.
package core_run_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RUN_HOLD,
    RUN_RUN,
    RUN_DONE
  } run_state_e;

  typedef enum logic [1:0] {
    END_NONE,
    END_HALT,
    END_FAULT,
    END_TIMEOUT
  } run_end_e;

endpackage : core_run_pkg

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle RV32I core.
//
// Holds the core in reset for RESET_CYCLES cycles, lets it run while counting
// cycles, and ends the run when the core reaches HALT_PC, sits on the same PC
// for two consecutive cycles, takes a misaligned access, or exhausts the
// cycle budget. A restart pulse in DONE re-runs the whole sequence.
//
// Ports:
//   clk          in   1      single clock
//   reset        in   1      synchronous, active-high
//   pc           in   XLEN   core's current PC
//   misaligned   in   1      core's misaligned-access flag for this instruction
//   restart      in   1      one-cycle pulse; honoured only in DONE
//   core_reset   out  1      reset to the core; high while in HOLD
//   running      out  1      high in RUN
//   done         out  1      high in DONE
//   halted       out  1      run ended on HALT_PC or self-loop
//   fault        out  1      run ended on misaligned access
//   timeout      out  1      run ended on cycle budget
//   cycle_count  out  XLEN   RUN cycles elapsed; frozen in DONE
//   end_pc       out  XLEN   PC sampled on the terminating cycle
//
// All outputs are registers; each is loaded from its next-state value so no
// input reaches an output combinationally.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned       RESET_CYCLES     = 5,
  parameter logic [XLEN-1:0]   HALT_PC          = 32'h0000_0094,
  parameter longint unsigned   MAX_CYCLES       = 300,
  parameter bit                LOOP_DETECT      = 1'b1,
  parameter bit                STOP_ON_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            misaligned,
  input  logic            restart,
  output logic            core_reset,
  output logic            running,
  output logic            done,
  output logic            halted,
  output logic            fault,
  output logic            timeout,
  output logic [XLEN-1:0] cycle_count,
  output logic [XLEN-1:0] end_pc
);

  // Terminal counts, precomputed at full width so comparisons match.
  localparam logic [31:0]     HOLD_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [XLEN-1:0] CYCLE_LAST = XLEN'(MAX_CYCLES - 1);

  run_state_e      state, state_next;
  logic [31:0]     hold_cnt, hold_cnt_next;
  logic [XLEN-1:0] prev_pc, prev_pc_next;
  logic            prev_valid, prev_valid_next;
  logic [XLEN-1:0] cycle_count_next;
  logic [XLEN-1:0] end_pc_next;
  logic            halted_next, fault_next, timeout_next;
  run_end_e        end_cause;

  // Classify the current RUN cycle. The order of the tests is the priority:
  // halt PC beats self-loop beats misalign beats timeout.
  always_comb begin
    end_cause = END_NONE;
    if (pc == HALT_PC) begin
      end_cause = END_HALT;
    end else if (LOOP_DETECT && prev_valid && (pc == prev_pc)) begin
      end_cause = END_HALT;
    end else if (STOP_ON_MISALIGN && misaligned) begin
      end_cause = END_FAULT;
    end else if (cycle_count == CYCLE_LAST) begin
      end_cause = END_TIMEOUT;
    end
  end

  // Next-state and next-output logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    hold_cnt_next    = hold_cnt;
    prev_pc_next     = prev_pc;
    prev_valid_next  = prev_valid;
    cycle_count_next = cycle_count;
    end_pc_next      = end_pc;
    halted_next      = halted;
    fault_next       = fault;
    timeout_next     = timeout;

    unique case (state)
      RUN_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next       = RUN_RUN;
          hold_cnt_next    = '0;
          // Entering RUN: the first PC must never match a stale prev_pc.
          prev_valid_next  = 1'b0;
          cycle_count_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + 32'd1;
        end
      end

      RUN_RUN: begin
        if (end_cause != END_NONE) begin
          state_next   = RUN_DONE;
          end_pc_next  = pc;
          halted_next  = (end_cause == END_HALT);
          fault_next   = (end_cause == END_FAULT);
          timeout_next = (end_cause == END_TIMEOUT);
        end else begin
          // The terminating cycle itself is not counted.
          cycle_count_next = cycle_count + XLEN'(1);
          prev_pc_next     = pc;
          prev_valid_next  = 1'b1;
        end
      end

      RUN_DONE: begin
        if (restart) begin
          state_next       = RUN_HOLD;
          hold_cnt_next    = '0;
          prev_valid_next  = 1'b0;
          cycle_count_next = '0;
          end_pc_next      = '0;
          halted_next      = 1'b0;
          fault_next       = 1'b0;
          timeout_next     = 1'b0;
        end
      end

      default: begin
        state_next = RUN_HOLD;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN_HOLD;
      hold_cnt    <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
      cycle_count <= '0;
      end_pc      <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      timeout     <= 1'b0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      prev_pc     <= prev_pc_next;
      prev_valid  <= prev_valid_next;
      cycle_count <= cycle_count_next;
      end_pc      <= end_pc_next;
      halted      <= halted_next;
      fault       <= fault_next;
      timeout     <= timeout_next;
      // State decodes are registered from the next state so they track
      // the state register exactly without a combinational output path.
      core_reset  <= (state_next == RUN_HOLD);
      running     <= (state_next == RUN_RUN);
      done        <= (state_next == RUN_DONE);
    end
  end

endmodule : core_run_ctrl

// File: tb/tb_core_run_ctrl.sv
// Directed testbench for core_run_ctrl.
//
// Two instances share all inputs: dut uses default parameters, dut_nl has
// self-loop detection disabled. Inputs are driven and outputs sampled 1 ns
// after each rising edge; every check goes through check().
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        misaligned;
  logic        restart;

  logic        core_reset, running, done, halted, fault, timeout;
  logic [31:0] cycle_count, end_pc;

  logic        core_reset_nl, running_nl, done_nl, halted_nl, fault_nl, timeout_nl;
  logic [31:0] cycle_count_nl, end_pc_nl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .misaligned  (misaligned),
    .restart     (restart),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .halted      (halted),
    .fault       (fault),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .end_pc      (end_pc)
  );

  core_run_ctrl #(.LOOP_DETECT(1'b0)) dut_nl (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .misaligned  (misaligned),
    .restart     (restart),
    .core_reset  (core_reset_nl),
    .running     (running_nl),
    .done        (done_nl),
    .halted      (halted_nl),
    .fault       (fault_nl),
    .timeout     (timeout_nl),
    .cycle_count (cycle_count_nl),
    .end_pc      (end_pc_nl)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every output against the reset values.
  task automatic check_reset_values(input string tag);
    check({tag, " core_reset"}, 32'(core_reset), 32'd1);
    check({tag, " running"},    32'(running),    32'd0);
    check({tag, " done"},       32'(done),       32'd0);
    check({tag, " halted"},     32'(halted),     32'd0);
    check({tag, " fault"},      32'(fault),      32'd0);
    check({tag, " timeout"},    32'(timeout),    32'd0);
    check({tag, " cycle_count"}, cycle_count,    32'd0);
    check({tag, " end_pc"},     end_pc,          32'd0);
  endtask

  // The HOLD phase after reset release or restart: core_reset stays high for
  // edges 1..4 and falls, with running rising, on edge 5.
  task automatic hold_phase(input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("%s hold%0d core_reset", tag, k), 32'(core_reset), 32'd1);
      check($sformatf("%s hold%0d running", tag, k), 32'(running), 32'd0);
    end
    tick();
    check({tag, " release core_reset"}, 32'(core_reset), 32'd0);
    check({tag, " release running"},    32'(running),    32'd1);
    check({tag, " release cycle_count"}, cycle_count,    32'd0);
  endtask

  task automatic start_run(input string tag);
    reset      = 1'b1;
    pc         = 32'd0;
    misaligned = 1'b0;
    restart    = 1'b0;
    repeat (3) tick();
    check_reset_values({tag, " rst"});
    reset = 1'b0;
    hold_phase(tag);
  endtask

  // PC 0x00, 0x04, ..., 0x94: 37 counted cycles then the halt cycle.
  task automatic normal_halt_seq(input string tag);
    for (int i = 0; i < 37; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    check({tag, " pre running"}, 32'(running), 32'd1);
    check({tag, " pre done"},    32'(done),    32'd0);
    pc = 32'h94;
    tick();
    check({tag, " done"},        32'(done),    32'd1);
    check({tag, " running"},     32'(running), 32'd0);
    check({tag, " halted"},      32'(halted),  32'd1);
    check({tag, " fault"},       32'(fault),   32'd0);
    check({tag, " timeout"},     32'(timeout), 32'd0);
    check({tag, " end_pc"},      end_pc,       32'h94);
    check({tag, " cycle_count"}, cycle_count,  32'd37);
    check({tag, " core_reset"},  32'(core_reset), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    pc         = 32'd0;
    misaligned = 1'b0;
    restart    = 1'b0;

    // Reset release and normal halt.
    start_run("first");
    normal_halt_seq("halt");

    // Restart ignored? No: in DONE it re-runs; check reset + restart together
    // first, where reset must win with plain reset values.
    reset   = 1'b1;
    restart = 1'b1;
    tick();
    check_reset_values("rst+restart");
    reset   = 1'b0;
    restart = 1'b0;

    // Self-loop: 0x00, 0x04, 0x08, 0x08.
    start_run("loop");
    pc = 32'h00; tick();
    pc = 32'h04; tick();
    pc = 32'h08; tick();
    check("loop pre done", 32'(done), 32'd0);
    pc = 32'h08; tick();
    check("loop done",        32'(done),   32'd1);
    check("loop halted",      32'(halted), 32'd1);
    check("loop end_pc",      end_pc,      32'h08);
    check("loop cycle_count", cycle_count, 32'd3);
    check("noloop done",        32'(done_nl),    32'd0);
    check("noloop running",     32'(running_nl), 32'd1);
    check("noloop cycle_count", cycle_count_nl,  32'd4);

    // Misaligned access at 0x10.
    start_run("mis");
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    pc         = 32'h10;
    misaligned = 1'b1;
    tick();
    misaligned = 1'b0;
    check("mis done",        32'(done),   32'd1);
    check("mis fault",       32'(fault),  32'd1);
    check("mis halted",      32'(halted), 32'd0);
    check("mis end_pc",      end_pc,      32'h10);
    check("mis cycle_count", cycle_count, 32'd4);

    // Misaligned together with the halt PC: halt has priority.
    start_run("mishalt");
    pc = 32'h00; tick();
    pc         = 32'h94;
    misaligned = 1'b1;
    tick();
    misaligned = 1'b0;
    check("mishalt halted", 32'(halted), 32'd1);
    check("mishalt fault",  32'(fault),  32'd0);
    check("mishalt end_pc", end_pc,      32'h94);

    // Timeout: PCs from 0x200 upward never hit 0x94 nor repeat.
    start_run("tmo");
    for (int i = 0; i < 299; i++) begin
      pc = 32'h200 + 32'(i * 4);
      tick();
    end
    check("tmo pre done",        32'(done),   32'd0);
    check("tmo pre cycle_count", cycle_count, 32'd299);
    pc = 32'h6ac;
    tick();
    check("tmo done",        32'(done),    32'd1);
    check("tmo timeout",     32'(timeout), 32'd1);
    check("tmo halted",      32'(halted),  32'd0);
    check("tmo fault",       32'(fault),   32'd0);
    check("tmo cycle_count", cycle_count,  32'd299);
    check("tmo end_pc",      end_pc,       32'h6ac);

    // DONE holds its outputs while the core keeps running.
    pc = 32'h94;
    repeat (3) tick();
    check("hold done",        32'(done),    32'd1);
    check("hold timeout",     32'(timeout), 32'd1);
    check("hold halted",      32'(halted),  32'd0);
    check("hold cycle_count", cycle_count,  32'd299);
    check("hold end_pc",      end_pc,       32'h6ac);

    // Restart from DONE: back to HOLD with cleared status, then an identical run.
    pc      = 32'd0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs core_reset",  32'(core_reset), 32'd1);
    check("rs done",        32'(done),       32'd0);
    check("rs running",     32'(running),    32'd0);
    check("rs timeout",     32'(timeout),    32'd0);
    check("rs cycle_count", cycle_count,     32'd0);
    check("rs end_pc",      end_pc,          32'd0);
    hold_phase("rs");
    normal_halt_seq("rs halt");

    // Restart during RUN is ignored; reset at cycle_count 20 wins immediately.
    start_run("mid");
    for (int i = 0; i < 20; i++) begin
      pc      = 32'(i * 4);
      restart = (i == 10);
      tick();
    end
    restart = 1'b0;
    check("mid running",     32'(running), 32'd1);
    check("mid core_reset",  32'(core_reset), 32'd0);
    check("mid cycle_count", cycle_count,  32'd20);
    reset = 1'b1;
    pc    = 32'h50;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_core_run_ctrl
